// File: rtl/i2c_pkg.sv
// Shared types and constants for the write-only I2C master on the FIFO read side.
package i2c_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      ADDR,
      ACK1,
      DATA,
      ACK2,
      STOP
   } i2c_state_e;

   // Quarter index within a bit slot or START/STOP condition.
   typedef logic [1:0] qidx_t;

   // R/W bit appended to the slave address; this master only writes.
   localparam logic I2C_WRITE = 1'b0;

endpackage

// File: rtl/i2c_qtick_gen.sv
// Quarter-period timebase: DIV rd_clk cycles per quarter, quarter index 0..3.
module i2c_qtick_gen
   import i2c_pkg::*;
#(
   parameter int unsigned DIV = 4
) (
   input  logic  rd_clk,
   input  logic  rd_rst,
   input  logic  enable,
   output logic  tick,
   output qidx_t q
);

   localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] QMAX = CW'(DIV - 1);

   logic [CW-1:0] qcnt;

   assign tick = enable && (qcnt == QMAX);

   // Count cycles within a quarter and advance the quarter index on each tick; parked at 0 while disabled.
   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         qcnt <= '0;
         q    <= '0;
      end else if (!enable) begin
         qcnt <= '0;
         q    <= '0;
      end else if (qcnt == QMAX) begin
         qcnt <= '0;
         q    <= q + 2'd1;
      end else begin
         qcnt <= qcnt + 1'b1;
      end
   end

endmodule

// File: rtl/i2c_fifo_master_tx.sv
// Write-only I2C master: pops one FIFO byte per transaction and sends START, address+W, data, STOP.
module i2c_fifo_master_tx
   import i2c_pkg::*;
#(
   parameter int unsigned DIV        = 4,
   parameter logic [6:0]  SLAVE_ADDR = 7'h50
) (
   input  logic       rd_clk,
   input  logic       rd_rst,
   input  logic [7:0] rd_data,
   input  logic       rd_empty,
   output logic       rd_en,
   output logic       scl,
   output logic       sda,
   input  logic       sda_in,
   output logic       busy,
   output logic       nack
);

   localparam logic [7:0] ADDR_BYTE = {SLAVE_ADDR, I2C_WRITE};

   i2c_state_e state;
   logic [7:0] data_reg;
   logic [7:0] shreg;
   logic [2:0] bit_cnt;
   logic       nack_flag;
   logic       timed;
   logic       tick;
   qidx_t      q;

   assign rd_en = (state == IDLE) && !rd_empty;
   assign busy  = (state != IDLE);
   // LOAD is a single untimed cycle; quarters only run in the bus states.
   assign timed = (state != IDLE) && (state != LOAD);

   i2c_qtick_gen #(
      .DIV(DIV)
   ) u_qtick (
      .rd_clk(rd_clk),
      .rd_rst(rd_rst),
      .enable(timed),
      .tick  (tick),
      .q     (q)
   );

   // Transaction FSM; scl/sda are set on each tick to the level of the quarter that follows it.
   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         state     <= IDLE;
         scl       <= 1'b1;
         sda       <= 1'b1;
         nack      <= 1'b0;
         nack_flag <= 1'b0;
         data_reg  <= '0;
         shreg     <= '0;
         bit_cnt   <= '0;
      end else begin
         nack <= 1'b0;
         unique case (state)
            IDLE: begin
               if (!rd_empty) state <= LOAD;
            end
            LOAD: begin
               data_reg  <= rd_data;
               nack_flag <= 1'b0;
               state     <= START;
            end
            START: begin
               if (tick) begin
                  case (q)
                     2'd0: sda <= 1'b0;
                     2'd1: scl <= 1'b0;
                     2'd3: begin
                        state   <= ADDR;
                        bit_cnt <= 3'd7;
                        sda     <= ADDR_BYTE[7];
                        shreg   <= {ADDR_BYTE[6:0], 1'b0};
                     end
                     default: ;
                  endcase
               end
            end
            ADDR, DATA: begin
               if (tick) begin
                  case (q)
                     2'd1: scl <= 1'b1;
                     2'd3: begin
                        scl <= 1'b0;
                        if (bit_cnt == 3'd0) begin
                           sda   <= 1'b1;
                           state <= (state == ADDR) ? ACK1 : ACK2;
                        end else begin
                           bit_cnt <= bit_cnt - 3'd1;
                           sda     <= shreg[7];
                           shreg   <= {shreg[6:0], 1'b0};
                        end
                     end
                     default: ;
                  endcase
               end
            end
            ACK1, ACK2: begin
               if (tick) begin
                  case (q)
                     2'd1: scl <= 1'b1;
                     2'd2: begin
                        if (sda_in) begin
                           nack      <= 1'b1;
                           nack_flag <= 1'b1;
                        end
                     end
                     2'd3: begin
                        scl <= 1'b0;
                        if ((state == ACK1) && !nack_flag) begin
                           state   <= DATA;
                           bit_cnt <= 3'd7;
                           sda     <= data_reg[7];
                           shreg   <= {data_reg[6:0], 1'b0};
                        end else begin
                           state <= STOP;
                           sda   <= 1'b0;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            STOP: begin
               if (tick) begin
                  case (q)
                     2'd0: scl <= 1'b1;
                     2'd1: sda <= 1'b1;
                     2'd3: state <= IDLE;
                     default: ;
                  endcase
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
